// File: rtl/pe_pkg.sv
// Shared definitions for the PE operand feeder: default widths and the job FSM encoding.
package pe_pkg;

    localparam int DefDataInWidth  = 32;
    localparam int DefDataOutWidth = 64;
    localparam int DefCountWidth   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

    function automatic logic allIdle(input logic a, input logic b, input logic c);
        return ~(a | b | c);
    endfunction

endpackage

// File: rtl/out_reg_slice.sv
// One-entry valid/ready output register; a reload in the same cycle as a
// handshake keeps valid high so back-to-back transfers run at full rate.
module out_reg_slice #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [Width-1:0] i_data,
    input  logic             i_rdy,
    output logic [Width-1:0] o_data,
    output logic             o_valid,
    output logic             o_free
);

    logic [Width-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_rdy) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_free  = ~r_valid | i_rdy;

endmodule

// File: rtl/pe_feeder.sv
// Feeds weight/input/psum-seed operand triples to a PE for a Len-long job and
// forwards the PE's MAC results downstream, pulsing Done once all are collected.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int DataInWidth  = DefDataInWidth,
    parameter int DataOutWidth = DefDataOutWidth,
    parameter int CountWidth   = DefCountWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Start,
    input  logic [CountWidth-1:0]   Len,
    input  logic [DataInWidth-1:0]  Bias,
    output logic                    Busy,
    output logic                    Done,
    input  logic [DataInWidth-1:0]  Src_W_Data,
    input  logic [DataInWidth-1:0]  Src_I_Data,
    input  logic                    Src_Valid,
    output logic                    Src_Rdy,
    output logic [DataInWidth-1:0]  W_DataOut,
    output logic                    W_DataOutValid,
    input  logic                    W_DataOutRdy,
    output logic [DataInWidth-1:0]  I_DataOut,
    output logic                    I_DataOutValid,
    input  logic                    I_DataOutRdy,
    output logic [DataInWidth-1:0]  O_DataOut,
    output logic                    O_DataOutValid,
    input  logic                    O_DataOutRdy,
    input  logic [DataOutWidth-1:0] R_DataIn,
    input  logic                    R_DataInValid,
    output logic                    R_DataInRdy,
    output logic [DataOutWidth-1:0] Res_Data,
    output logic                    Res_Valid,
    input  logic                    Res_Rdy
);

    feeder_state_e r_state;
    feeder_state_e w_nextState;

    logic [CountWidth-1:0]  r_len;
    logic [DataInWidth-1:0] r_bias;
    logic [CountWidth-1:0]  r_sentCnt;
    logic [CountWidth-1:0]  r_recvCnt;
    logic                   r_done;

    logic w_busy;
    logic w_startJob;
    logic w_doneNext;
    logic w_wFree;
    logic w_iFree;
    logic w_oFree;
    logic w_resFree;
    logic w_srcRdy;
    logic w_srcFire;
    logic w_resRdy;
    logic w_resFire;

    assign w_busy    = (r_state != IDLE);
    // A new triple may only enter when every lane can take it, so the lanes stay in lockstep.
    assign w_srcRdy  = (r_state == FEED) && (r_sentCnt < r_len) && w_wFree && w_iFree && w_oFree;
    assign w_srcFire = Src_Valid & w_srcRdy;
    assign w_resRdy  = w_busy & w_resFree;
    assign w_resFire = R_DataInValid & w_resRdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_startJob  = 1'b0;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (Len != '0) begin
                        w_startJob  = 1'b1;
                        w_nextState = FEED;
                    end else begin
                        w_doneNext = 1'b1;
                    end
                end
            end
            FEED: begin
                if ((r_sentCnt == r_len) && allIdle(W_DataOutValid, I_DataOutValid, O_DataOutValid)) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (r_recvCnt == r_len) begin
                    w_nextState = IDLE;
                    w_doneNext  = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The receive counter saturates in case the PE returns more results than were fed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_bias    <= '0;
            r_sentCnt <= '0;
            r_recvCnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_doneNext;
            if (w_startJob) begin
                r_len     <= Len;
                r_bias    <= Bias;
                r_sentCnt <= '0;
                r_recvCnt <= '0;
            end else begin
                if (w_srcFire) begin
                    r_sentCnt <= r_sentCnt + CountWidth'(1);
                end
                if (w_resFire && (r_recvCnt != {CountWidth{1'b1}})) begin
                    r_recvCnt <= r_recvCnt + CountWidth'(1);
                end
            end
        end
    end

    out_reg_slice #(.Width(DataInWidth)) u_wSlice (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_srcFire),
        .i_data  (Src_W_Data),
        .i_rdy   (W_DataOutRdy),
        .o_data  (W_DataOut),
        .o_valid (W_DataOutValid),
        .o_free  (w_wFree)
    );

    out_reg_slice #(.Width(DataInWidth)) u_iSlice (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_srcFire),
        .i_data  (Src_I_Data),
        .i_rdy   (I_DataOutRdy),
        .o_data  (I_DataOut),
        .o_valid (I_DataOutValid),
        .o_free  (w_iFree)
    );

    out_reg_slice #(.Width(DataInWidth)) u_oSlice (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_srcFire),
        .i_data  (r_bias),
        .i_rdy   (O_DataOutRdy),
        .o_data  (O_DataOut),
        .o_valid (O_DataOutValid),
        .o_free  (w_oFree)
    );

    out_reg_slice #(.Width(DataOutWidth)) u_resSlice (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_resFire),
        .i_data  (R_DataIn),
        .i_rdy   (Res_Rdy),
        .o_data  (Res_Data),
        .o_valid (Res_Valid),
        .o_free  (w_resFree)
    );

    assign Busy        = w_busy;
    assign Done        = r_done;
    assign Src_Rdy     = w_srcRdy;
    assign R_DataInRdy = w_resRdy;

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: a behavioural PE and consumer sit around the DUT,
// expected operands and MAC results are queued at source acceptance and popped by a monitor.
module tb_pe_feeder;

    localparam int DW = 32;
    localparam int OW = 64;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          Start;
    logic [CW-1:0] Len;
    logic [DW-1:0] Bias;
    logic          Busy;
    logic          Done;
    logic [DW-1:0] Src_W_Data;
    logic [DW-1:0] Src_I_Data;
    logic          Src_Valid;
    logic          Src_Rdy;
    logic [DW-1:0] W_DataOut;
    logic          W_DataOutValid;
    logic          W_DataOutRdy;
    logic [DW-1:0] I_DataOut;
    logic          I_DataOutValid;
    logic          I_DataOutRdy;
    logic [DW-1:0] O_DataOut;
    logic          O_DataOutValid;
    logic          O_DataOutRdy;
    logic [OW-1:0] R_DataIn;
    logic          R_DataInValid;
    logic          R_DataInRdy;
    logic [OW-1:0] Res_Data;
    logic          Res_Valid;
    logic          Res_Rdy;

    pe_feeder #(.DataInWidth(DW), .DataOutWidth(OW), .CountWidth(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .Start          (Start),
        .Len            (Len),
        .Bias           (Bias),
        .Busy           (Busy),
        .Done           (Done),
        .Src_W_Data     (Src_W_Data),
        .Src_I_Data     (Src_I_Data),
        .Src_Valid      (Src_Valid),
        .Src_Rdy        (Src_Rdy),
        .W_DataOut      (W_DataOut),
        .W_DataOutValid (W_DataOutValid),
        .W_DataOutRdy   (W_DataOutRdy),
        .I_DataOut      (I_DataOut),
        .I_DataOutValid (I_DataOutValid),
        .I_DataOutRdy   (I_DataOutRdy),
        .O_DataOut      (O_DataOut),
        .O_DataOutValid (O_DataOutValid),
        .O_DataOutRdy   (O_DataOutRdy),
        .R_DataIn       (R_DataIn),
        .R_DataInValid  (R_DataInValid),
        .R_DataInRdy    (R_DataInRdy),
        .Res_Data       (Res_Data),
        .Res_Valid      (Res_Valid),
        .Res_Rdy        (Res_Rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] expW[$];
    logic [DW-1:0] expI[$];
    logic [DW-1:0] expO[$];
    logic [OW-1:0] expRes[$];
    logic [DW-1:0] peW[$];
    logic [DW-1:0] peI[$];
    logic [DW-1:0] peO[$];
    logic [OW-1:0] peRes[$];

    logic [DW-1:0] jobBias = '0;
    int  srcRemaining = 0;
    int  acceptCount = 0;
    int  firstAcceptCycle = 0;
    int  lastAcceptCycle = 0;
    int  lastRFireCycle = 0;
    int  lastDoneCycle = 0;
    int  doneCount = 0;
    int  cycle = 0;
    bit  srcFire = 1'b0;
    bit  prevDone = 1'b0;
    bit  randomRdy = 1'b0;
    bit  randomSrc = 1'b0;
    bit  iStall = 1'b0;
    bit  resHold = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: sees every handshake of the cycle at the negedge, before the edge that commits it.
    always @(negedge clk) begin
        cycle++;
        srcFire = 1'b0;
        if (rst) begin
            expW.delete(); expI.delete(); expO.delete(); expRes.delete();
            peW.delete(); peI.delete(); peO.delete(); peRes.delete();
            prevDone = 1'b0;
        end else begin
            if (Done) begin
                checkOutput("done_one_cycle", 64'(prevDone), 64'd0);
                doneCount++;
                lastDoneCycle = cycle;
            end
            prevDone = Done;
            checkOutput("r_rdy_rule", 64'(R_DataInRdy), 64'(Busy & (~Res_Valid | Res_Rdy)));

            if (Src_Valid && Src_Rdy) begin
                srcFire = 1'b1;
                expW.push_back(Src_W_Data);
                expI.push_back(Src_I_Data);
                expO.push_back(jobBias);
                expRes.push_back(64'(Src_W_Data) * 64'(Src_I_Data) + 64'(jobBias));
                if (acceptCount == 0) firstAcceptCycle = cycle;
                lastAcceptCycle = cycle;
                acceptCount++;
            end

            if (R_DataInValid && R_DataInRdy) begin
                lastRFireCycle = cycle;
                if (peRes.size() != 0) void'(peRes.pop_front());
            end

            if (W_DataOutValid && W_DataOutRdy) begin
                checkOutput("w_pending", 64'(expW.size() != 0), 64'd1);
                if (expW.size() != 0) checkOutput("w_data", 64'(W_DataOut), 64'(expW.pop_front()));
                peW.push_back(W_DataOut);
            end
            if (I_DataOutValid && I_DataOutRdy) begin
                checkOutput("i_pending", 64'(expI.size() != 0), 64'd1);
                if (expI.size() != 0) checkOutput("i_data", 64'(I_DataOut), 64'(expI.pop_front()));
                peI.push_back(I_DataOut);
            end
            if (O_DataOutValid && O_DataOutRdy) begin
                checkOutput("o_pending", 64'(expO.size() != 0), 64'd1);
                if (expO.size() != 0) checkOutput("o_data", 64'(O_DataOut), 64'(expO.pop_front()));
                peO.push_back(O_DataOut);
            end
            while (peW.size() != 0 && peI.size() != 0 && peO.size() != 0) begin
                peRes.push_back(64'(peW.pop_front()) * 64'(peI.pop_front()) + 64'(peO.pop_front()));
            end

            if (Res_Valid && Res_Rdy) begin
                checkOutput("res_pending", 64'(expRes.size() != 0), 64'd1);
                if (expRes.size() != 0) checkOutput("res_data", Res_Data, expRes.pop_front());
            end
        end
    end

    task automatic applyStimulus();
        Start = 1'b0;
        if (srcFire) srcRemaining--;
        if (srcRemaining > 0 && (!randomSrc || $urandom_range(0, 3) != 0)) begin
            Src_Valid  = 1'b1;
            Src_W_Data = $urandom;
            Src_I_Data = $urandom;
        end else begin
            Src_Valid = 1'b0;
        end
        W_DataOutRdy = randomRdy ? 1'($urandom_range(0, 1)) : 1'b1;
        O_DataOutRdy = randomRdy ? 1'($urandom_range(0, 1)) : 1'b1;
        I_DataOutRdy = iStall ? 1'b0 : (randomRdy ? 1'($urandom_range(0, 1)) : 1'b1);
        Res_Rdy      = resHold ? 1'b0 : (randomRdy ? 1'($urandom_range(0, 1)) : 1'b1);
        R_DataInValid = (peRes.size() != 0) && (!randomRdy || $urandom_range(0, 2) != 0);
        R_DataIn      = (peRes.size() != 0) ? peRes[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    task automatic startJob(input int len, input logic [DW-1:0] bias);
        tick();
        Start        = 1'b1;
        Len          = CW'(len);
        Bias         = bias;
        jobBias      = bias;
        srcRemaining = len;
        acceptCount  = 0;
        tick();
    endtask

    task automatic waitDone(input int budget, input string tag);
        int startCount = doneCount;
        for (int k = 0; k < budget && doneCount == startCount; k++) tick();
        checkOutput({tag, "_done_seen"}, 64'(doneCount > startCount), 64'd1);
    endtask

    task automatic finishJob(input int len, input string tag);
        waitDone(len * 40 + 100, tag);
        for (int k = 0; k < 300 && (expRes.size() != 0 || Res_Valid); k++) tick();
        checkOutput({tag, "_pairs_sent"}, 64'(acceptCount), 64'(len));
        checkOutput({tag, "_ops_left"}, 64'(expW.size() + expI.size() + expO.size()), 64'd0);
        checkOutput({tag, "_res_left"}, 64'(expRes.size()), 64'd0);
        checkOutput({tag, "_busy_after"}, 64'(Busy), 64'd0);
    endtask

    task automatic runJob(input int len, input logic [DW-1:0] bias, input string tag);
        startJob(len, bias);
        finishJob(len, tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int held;
        int doneBefore;
        rst = 1'b1;
        Start = 1'b0; Len = '0; Bias = '0;
        Src_Valid = 1'b0; Src_W_Data = '0; Src_I_Data = '0;
        R_DataIn = '0; R_DataInValid = 1'b0;
        W_DataOutRdy = 1'b1; I_DataOutRdy = 1'b1; O_DataOutRdy = 1'b1; Res_Rdy = 1'b1;
        repeat (3) tick();
        checkOutput("rst_busy", 64'(Busy), 64'd0);
        checkOutput("rst_done", 64'(Done), 64'd0);
        checkOutput("rst_src_rdy", 64'(Src_Rdy), 64'd0);
        checkOutput("rst_valids", 64'({W_DataOutValid, I_DataOutValid, O_DataOutValid, Res_Valid}), 64'd0);
        checkOutput("rst_r_rdy", 64'(R_DataInRdy), 64'd0);
        checkOutput("rst_data", 64'(W_DataOut | I_DataOut | O_DataOut) | Res_Data, 64'd0);
        rst = 1'b0;
        tick();

        // Full-rate job: three consecutive pairs, Done two monitor cycles after last result.
        runJob(3, 32'd5, "basic");
        checkOutput("basic_consecutive", 64'(lastAcceptCycle - firstAcceptCycle), 64'd2);
        checkOutput("basic_done_latency", 64'(lastDoneCycle - lastRFireCycle), 64'd2);

        // Zero-length job.
        tick();
        Start = 1'b1; Len = '0; Bias = 32'h77;
        tick();
        checkOutput("len0_done", 64'(Done), 64'd1);
        checkOutput("len0_busy", 64'(Busy), 64'd0);
        checkOutput("len0_valids", 64'({W_DataOutValid, I_DataOutValid, O_DataOutValid}), 64'd0);
        tick();
        checkOutput("len0_done_drop", 64'(Done), 64'd0);

        // Input lane stalled: W and O drain, I holds, source blocked.
        iStall = 1'b1;
        startJob(2, 32'h1234);
        for (int k = 0; k < 20 && !I_DataOutValid; k++) tick();
        checkOutput("stall_i_valid_seen", 64'(I_DataOutValid), 64'd1);
        held = int'(I_DataOut);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("stall_i_hold_valid", 64'(I_DataOutValid), 64'd1);
            checkOutput("stall_i_hold_data", 64'(I_DataOut), 64'(unsigned'(held)));
            checkOutput("stall_src_blocked", 64'(Src_Rdy), 64'd0);
            checkOutput("stall_w_drained", 64'(W_DataOutValid | O_DataOutValid), 64'd0);
        end
        iStall = 1'b0;
        finishJob(2, "stall");

        // Consumer backpressure: second result waits behind the held one.
        resHold = 1'b1;
        startJob(2, 32'h20);
        for (int k = 0; k < 30 && !(Res_Valid && R_DataInValid); k++) tick();
        checkOutput("hold_second_pending", 64'(Res_Valid & R_DataInValid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("hold_r_rdy", 64'(R_DataInRdy), 64'd0);
            checkOutput("hold_res_valid", 64'(Res_Valid), 64'd1);
            checkOutput("hold_busy", 64'(Busy), 64'd1);
            if (expRes.size() != 0) checkOutput("hold_res_data", Res_Data, expRes[0]);
        end
        resHold = 1'b0;
        finishJob(2, "hold");

        // Start while busy must not disturb the running job.
        startJob(4, 32'h11);
        tick();
        checkOutput("restart_busy", 64'(Busy), 64'd1);
        Start = 1'b1; Len = CW'(9); Bias = 32'h99;
        tick();
        finishJob(4, "restart");

        // Reset mid-job aborts without Done; a fresh job then runs normally.
        randomSrc = 1'b1;
        startJob(3, 32'h42);
        for (int k = 0; k < 30 && acceptCount == 0; k++) tick();
        checkOutput("abort_pair_sent", 64'(acceptCount != 0), 64'd1);
        doneBefore = doneCount;
        rst = 1'b1;
        srcRemaining = 0;
        tick();
        checkOutput("abort_busy", 64'(Busy), 64'd0);
        checkOutput("abort_valids", 64'({W_DataOutValid, I_DataOutValid, O_DataOutValid, Res_Valid}), 64'd0);
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("abort_no_done", 64'(doneCount - doneBefore), 64'd0);
        randomSrc = 1'b0;
        runJob(1, 32'h3, "after_abort");

        // Randomised jobs with random backpressure on every lane.
        randomRdy = 1'b1;
        randomSrc = 1'b1;
        for (int j = 0; j < 12; j++) begin
            runJob(int'($urandom_range(1, 20)), $urandom, "rand");
        end
        randomRdy = 1'b0;
        randomSrc = 1'b0;

        // Longest job the counters allow.
        runJob(255, $urandom, "maxlen");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameters SHALL be: DataInWidth, default 32, operand width; DataOutWidth, default 64, result width; CountWidth, default 8, width of Len and the internal counters.
REQ-002 There SHALL be one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-003 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 Start  in  1  one-cycle job start pulse
 Len  in  CountWidth  operand pairs in the job, sampled on Start
 Bias  in  DataInWidth  partial-sum seed, sampled on Start
 Busy  out  1  a job is in progress
 Done  out  1  one-cycle pulse when the job completes
 Src_W_Data  in  DataInWidth  upstream weight operand
 Src_I_Data  in  DataInWidth  upstream input operand
 Src_Valid  in  1  upstream operand pair valid
 Src_Rdy  out  1  feeder accepts the pair
 W_DataOut  out  DataInWidth  weight to PE
 W_DataOutValid  out  1  weight valid
 W_DataOutRdy  in  1  PE weight buffer ready
 I_DataOut  out  DataInWidth  input to PE
 I_DataOutValid  out  1  input valid
 I_DataOutRdy  in  1  PE input buffer ready
 O_DataOut  out  DataInWidth  partial-sum seed to PE
 O_DataOutValid  out  1  seed valid
 O_DataOutRdy  in  1  PE psum buffer ready
 R_DataIn  in  DataOutWidth  MAC result from PE
 R_DataInValid  in  1  result valid
 R_DataInRdy  out  1  feeder accepts the result
 Res_Data  out  DataOutWidth  result to consumer
 Res_Valid  out  1  result valid
 Res_Rdy  in  1  consumer ready

Function
REQ-004 The FSM SHALL have three states, IDLE, FEED and DRAIN; Busy SHALL be 1 in FEED and DRAIN.
REQ-005 In IDLE, Start=1 with Len>0 SHALL latch Len and Bias, clear SentCnt and RecvCnt, and enter FEED next cycle; Start in FEED or DRAIN SHALL be ignored.
REQ-006 In IDLE, Start=1 with Len=0 SHALL pulse Done the next cycle and stay in IDLE.
REQ-007 Each of the W, I and O streams SHALL use a one-entry output register; a stream is free when its valid is 0 or its valid&rdy is 1 in that cycle.
REQ-008 Src_Rdy SHALL equal (state==FEED) & (SentCnt<Len) & all three streams free; Src_Rdy is combinational from the three Rdy inputs.
REQ-009 A source handshake (Src_Valid&Src_Rdy) at cycle t SHALL load W=Src_W_Data, I=Src_I_Data and O=latched Bias, set all three valids at t+1, and increment SentCnt.
REQ-010 Each stream valid SHALL clear independently on its own valid&rdy, unless it is reloaded in the same cycle; streams are never lost, duplicated or reordered.
REQ-011 When SentCnt reaches Len and all three stream valids are 0, FEED SHALL go to DRAIN.
REQ-012 R_DataInRdy SHALL equal Busy & (~Res_Valid | Res_Rdy); results are accepted in both FEED and DRAIN.
REQ-013 A result handshake at t SHALL load Res_Data=R_DataIn, set Res_Valid at t+1, and increment RecvCnt; Res_Valid SHALL clear on Res_Valid&Res_Rdy unless reloaded.
REQ-014 Done SHALL pulse for one cycle, and the state SHALL return to IDLE, in the cycle after RecvCnt reaches Len while in DRAIN; a pending Res_Valid SHALL persist across this transition.
REQ-015 SentCnt and RecvCnt SHALL be CountWidth wide and SHALL never wrap; Len is at most 2^CountWidth-1.
REQ-016 Results arriving while Busy=0 SHALL NOT be accepted (R_DataInRdy=0).

Reset
REQ-017 rst=1 SHALL, on the next clock edge, force IDLE, clear both counters, and set Busy, Done, Src_Rdy, all three stream valids, Res_Valid and R_DataInRdy to 0; data registers SHALL be 0.
REQ-018 rst asserted mid-job SHALL abort the job without a Done pulse, and drop any held operands and results.

Structure
REQ-019 The FSM state encoding and default widths SHALL live in a shared package, pe_pkg.
REQ-020 The one-entry valid/ready output register SHALL be a single sub-module, out_reg_slice, instantiated four times (W, I, O and Res).

Verification
REQ-021 Len=3, Bias=5, all Rdy=1, source always valid -> three pairs on consecutive cycles, each with O_DataOut=5; Done one cycle after the third result.
REQ-022 Len=2, I_DataOutRdy=0 for 4 cycles -> W/O handshake once, I holds its data, Src_Rdy=0 until I drains; no pair lost.
REQ-023 Len=0 Start -> Done=1 next cycle, Busy stays 0, no stream valid.
REQ-024 Res_Rdy=0 with one result held -> R_DataInRdy=0 and the second result waits; Res_Rdy=1 -> both delivered in order.
REQ-025 rst mid-FEED after one pair sent -> all valids 0 and IDLE next cycle, no Done; a new Start with Len=1 completes normally.
REQ-026 Start asserted while Busy -> ignored; Len and Bias unchanged.
